// File: rtl/crc_decoding.sv
// crc_decoding: serial USB packet receiver. Captures PID and body from an
// unstuffed LSB-first bit stream, checks PID, CRC5/CRC16 and body length,
// and reports the parsed fields with a one-cycle pktValid strobe.
module crc_decoding (
    input  logic        clk,
    input  logic        rst,
    input  logic        bitIn,
    input  logic        bitValid,
    input  logic        eop,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [63:0] data,
    output logic [3:0]  dataLen,
    output logic        pktValid,
    output logic        pidErr,
    output logic        crcErr,
    output logic        lenErr
);

    localparam int unsigned BODY_W  = 80;
    localparam int unsigned CNT_SAT = 81;
    localparam int unsigned MAX_LEN = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PID    = 2'd1;
    localparam logic [1:0] ST_BODY   = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    logic [1:0]  state, state_n;
    logic [7:0]  pid_reg, pid_reg_n;
    logic [3:0]  pid_cnt, pid_cnt_n;
    logic [79:0] body, body_n;
    logic [6:0]  body_cnt, body_cnt_n;
    logic [4:0]  crc5, crc5_n;
    logic [15:0] crc16, crc16_n;
    logic        fb5, fb16;

    logic        pid_err_c, len_ok_c, crc_ok_c, len_err_c, crc_err_c;
    logic [6:0]  addr_c;
    logic [3:0]  endp_c;
    logic [63:0] data_c;
    logic [3:0]  len_c;

    // Next-state and capture datapath: the bit accepted this cycle is folded in
    always_comb begin
        state_n    = state;
        pid_reg_n  = pid_reg;
        pid_cnt_n  = pid_cnt;
        body_n     = body;
        body_cnt_n = body_cnt;
        crc5_n     = crc5;
        crc16_n    = crc16;
        fb5        = 1'b0;
        fb16       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bitValid) begin
                    pid_reg_n  = {7'd0, bitIn};
                    pid_cnt_n  = 4'd1;
                    body_cnt_n = 7'd0;
                    state_n    = ST_PID;
                end
            end
            ST_PID: begin
                if (bitValid) begin
                    pid_reg_n[pid_cnt[2:0]] = bitIn;
                    pid_cnt_n = pid_cnt + 4'd1;
                    if (pid_cnt == 4'd7) begin
                        state_n = ST_BODY;
                        crc5_n  = '1;
                        crc16_n = '1;
                    end
                end
                if (eop) begin
                    state_n = ST_REPORT;
                end
            end
            ST_BODY: begin
                if (bitValid) begin
                    if (body_cnt < 7'(BODY_W)) begin
                        body_n[body_cnt] = bitIn;
                    end
                    if (body_cnt < 7'(CNT_SAT)) begin
                        body_cnt_n = body_cnt + 7'd1;
                    end
                    fb5     = crc5[4] ^ bitIn;
                    crc5_n  = {crc5[3], crc5[2], crc5[1] ^ fb5, crc5[0], fb5};
                    fb16    = crc16[15] ^ bitIn;
                    crc16_n = {crc16[14] ^ fb16, crc16[13:2], crc16[1] ^ fb16, crc16[0], fb16};
                end
                if (eop) begin
                    state_n = ST_REPORT;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Packet evaluation on the post-update capture values
    always_comb begin
        pid_err_c = (pid_cnt_n != 4'd8) || (pid_reg_n[7:4] != ~pid_reg_n[3:0]);
        len_ok_c  = 1'b0;
        crc_ok_c  = 1'b1;
        addr_c    = 7'd0;
        endp_c    = 4'd0;
        data_c    = 64'd0;
        len_c     = 4'((body_cnt_n - 7'd16) >> 3);
        case (pid_reg_n[1:0])
            2'b01: begin
                len_ok_c = (body_cnt_n == 7'd16);
                crc_ok_c = (crc5_n == CRC5_RESIDUAL);
            end
            2'b11: begin
                len_ok_c = (body_cnt_n >= 7'd16) && (body_cnt_n <= 7'(BODY_W))
                           && (body_cnt_n[2:0] == 3'd0);
                crc_ok_c = (crc16_n == CRC16_RESIDUAL);
            end
            2'b10: begin
                len_ok_c = (body_cnt_n == 7'd0);
            end
            default: begin
                len_ok_c = 1'b0;
            end
        endcase
        len_err_c = !pid_err_c && !len_ok_c;
        crc_err_c = !pid_err_c && len_ok_c && !crc_ok_c;
        if (!pid_err_c && len_ok_c) begin
            if (pid_reg_n[1:0] == 2'b01) begin
                addr_c = body_n[6:0];
                endp_c = body_n[10:7];
            end
            if (pid_reg_n[1:0] == 2'b11) begin
                for (int k = 0; k < int'(MAX_LEN); k++) begin
                    if (k < int'(len_c)) begin
                        data_c[8*k +: 8] = body_n[8*k +: 8];
                    end
                end
            end
        end
        if (pid_reg_n[1:0] != 2'b11 || pid_err_c || !len_ok_c) begin
            len_c = 4'd0;
        end
    end

    // State and capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pid_reg  <= 8'd0;
            pid_cnt  <= 4'd0;
            body     <= 80'd0;
            body_cnt <= 7'd0;
            crc5     <= '1;
            crc16    <= '1;
        end else begin
            state    <= state_n;
            pid_reg  <= pid_reg_n;
            pid_cnt  <= pid_cnt_n;
            body     <= body_n;
            body_cnt <= body_cnt_n;
            crc5     <= crc5_n;
            crc16    <= crc16_n;
        end
    end

    // Result registers: loaded on entry to REPORT, held until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            pktValid <= 1'b0;
            pid      <= 4'd0;
            addr     <= 7'd0;
            endp     <= 4'd0;
            data     <= 64'd0;
            dataLen  <= 4'd0;
            pidErr   <= 1'b0;
            crcErr   <= 1'b0;
            lenErr   <= 1'b0;
        end else begin
            pktValid <= (state_n == ST_REPORT);
            if (state_n == ST_REPORT) begin
                pid     <= pid_reg_n[3:0];
                addr    <= addr_c;
                endp    <= endp_c;
                data    <= data_c;
                dataLen <= len_c;
                pidErr  <= pid_err_c;
                crcErr  <= crc_err_c;
                lenErr  <= len_err_c;
            end
        end
    end

endmodule

// File: tb/tb_crc_decoding.sv
// tb_crc_decoding: directed and randomized packets against a bit-list
// reference model; every cycle's pktValid and each report are compared.
module tb_crc_decoding;

    logic        clk = 1'b0;
    logic        rst, bitIn, bitValid, eop;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic [3:0]  dataLen;
    logic        pktValid, pidErr, crcErr, lenErr;

    crc_decoding dut (
        .clk(clk), .rst(rst), .bitIn(bitIn), .bitValid(bitValid), .eop(eop),
        .pid(pid), .addr(addr), .endp(endp), .data(data), .dataLen(dataLen),
        .pktValid(pktValid), .pidErr(pidErr), .crcErr(crcErr), .lenErr(lenErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] data;
        logic [3:0]  len;
        logic        pe;
        logic        ce;
        logic        le;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    logic        bodyq[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          armed = 1'b0;

    logic        snap_pv, snap_pe, snap_ce, snap_le;
    logic [3:0]  snap_pid, snap_endp, snap_len;
    logic [6:0]  snap_addr;
    logic [63:0] snap_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Transmitted CRC bits (complemented remainder, high-order first) over bodyq[0 +: n]
    function automatic logic [15:0] crc_tx(input int n, input int w);
        logic [15:0] mask, poly, r, t;
        logic fb;
        mask = (w == 5) ? 16'h001F : 16'hFFFF;
        poly = (w == 5) ? 16'h0005 : 16'h8005;
        r = mask;
        t = '0;
        for (int i = 0; i < n; i++) begin
            fb = r[w-1] ^ bodyq[i];
            r  = (r << 1) & mask;
            if (fb) r = r ^ poly;
        end
        for (int j = 0; j < w; j++) t[j] = ~r[w-1-j];
        return t;
    endfunction

    task automatic push_field(input logic [63:0] v, input int w);
        for (int i = 0; i < w; i++) bodyq.push_back(v[i]);
    endtask

    task automatic push_crc(input int w);
        logic [15:0] t;
        t = crc_tx(bodyq.size(), w);
        for (int j = 0; j < w; j++) bodyq.push_back(t[j]);
    endtask

    // Expected report for npid PID bits of pidb followed by the bits in bodyq
    function automatic exp_t model(input int npid, input logic [7:0] pidb);
        exp_t e;
        logic [7:0] pm;
        logic [15:0] t;
        int n;
        bit len_ok, crc_ok;
        e.due = 0; e.addr = '0; e.endp = '0; e.data = '0; e.len = '0;
        pm = '0;
        for (int i = 0; i < 8; i++) if (i < npid) pm[i] = pidb[i];
        e.pid = pm[3:0];
        e.pe  = (npid < 8) || (pm[7:4] != ~pm[3:0]);
        n = bodyq.size();
        len_ok = 1'b0;
        crc_ok = 1'b1;
        case (pm[1:0])
            2'b01: begin
                len_ok = (n == 16);
                if (len_ok) begin
                    t = crc_tx(11, 5);
                    for (int j = 0; j < 5; j++) if (bodyq[11+j] !== t[j]) crc_ok = 1'b0;
                end
            end
            2'b11: begin
                len_ok = (n >= 16) && (n <= 80) && (n % 8 == 0);
                if (len_ok) begin
                    t = crc_tx(n - 16, 16);
                    for (int j = 0; j < 16; j++) if (bodyq[n-16+j] !== t[j]) crc_ok = 1'b0;
                end
            end
            2'b10: len_ok = (n == 0);
            default: len_ok = 1'b0;
        endcase
        e.le = !e.pe && !len_ok;
        e.ce = !e.pe && len_ok && !crc_ok;
        if (!e.pe && len_ok) begin
            if (pm[1:0] == 2'b01) begin
                for (int i = 0; i < 7; i++) e.addr[i] = bodyq[i];
                for (int i = 0; i < 4; i++) e.endp[i] = bodyq[7+i];
            end else if (pm[1:0] == 2'b11) begin
                e.len = 4'((n - 16) / 8);
                for (int i = 0; i < n - 16; i++) e.data[i] = bodyq[i];
            end
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic b, input logic e);
        @(posedge clk);
        #1;
        bitValid = v;
        bitIn    = b;
        eop      = e;
    endtask

    task automatic idle(input int gap);
        repeat ($urandom_range(0, gap)) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1; bitValid = 1'b0; eop = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Send one packet, queue its expected report and snapshot the REPORT cycle
    task automatic send(input int npid, input logic [7:0] pidb, input bit merge,
                        input int gap, input bit junk);
        exp_t e;
        int n;
        e = model(npid, pidb);
        n = bodyq.size();
        for (int i = 0; i < npid; i++) begin
            idle(gap);
            drive(1'b1, pidb[i], 1'b0);
        end
        for (int i = 0; i < n; i++) begin
            idle(gap);
            if (merge && i == n - 1) begin
                drive(1'b1, bodyq[i], 1'b1);
                e.due = cyc + 1;
                expq.push_back(e);
            end else begin
                drive(1'b1, bodyq[i], 1'b0);
            end
        end
        if (!(merge && n > 0)) begin
            idle(gap);
            drive(1'b0, 1'b0, 1'b1);
            e.due = cyc + 1;
            expq.push_back(e);
        end
        drive(junk, 1'($urandom), 1'b0);
        @(negedge clk);
        snap_pv = pktValid; snap_pid = pid; snap_addr = addr; snap_endp = endp;
        snap_data = data; snap_len = dataLen; snap_pe = pidErr; snap_ce = crcErr; snap_le = lenErr;
        if (junk) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Per-cycle comparison of the strobe and, when due, the whole report
    always @(negedge clk) begin
        if (armed) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                cur = expq.pop_front();
                chk("pktValid", 64'(pktValid), 64'd1);
                chk("pid", 64'(pid), 64'(cur.pid));
                chk("addr", 64'(addr), 64'(cur.addr));
                chk("endp", 64'(endp), 64'(cur.endp));
                chk("data", data, cur.data);
                chk("dataLen", 64'(dataLen), 64'(cur.len));
                chk("pidErr", 64'(pidErr), 64'(cur.pe));
                chk("crcErr", 64'(crcErr), 64'(cur.ce));
                chk("lenErr", 64'(lenErr), 64'(cur.le));
            end else begin
                chk("pktValid_quiet", 64'(pktValid), 64'd0);
            end
        end
    end

    initial begin
        logic [7:0] toks [4];
        logic [7:0] hsks [3];
        logic [4:0] f17;
        exp_t e;
        int kind, npid, len, n, pos;
        logic [7:0] pb;

        toks = '{8'hE1, 8'h69, 8'h2D, 8'hA5};
        hsks = '{8'hD2, 8'h5A, 8'h1E};
        rst = 1'b1; bitIn = 1'b0; bitValid = 1'b0; eop = 1'b0;

        do_reset(3);
        @(negedge clk);
        chk("rst_pktValid", 64'(pktValid), 64'd0);
        chk("rst_fields", {pid, addr, endp, dataLen}, 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_flags", {61'd0, pidErr, crcErr, lenErr}, 64'd0);
        armed = 1'b1;

        // OUT token, addr 0x15 endp 0xE, CRC field 0x17 sent high bit first
        bodyq.delete();
        push_field(64'h15, 7);
        push_field(64'hE, 4);
        f17 = 5'h17;
        for (int i = 4; i >= 0; i--) bodyq.push_back(f17[i]);
        chk("model_crc5_bits", 64'(crc_tx(11, 5)), 64'h1D);
        e = model(8, 8'hE1);
        chk("model_tok_crc", 64'(e.ce), 64'd0);
        send(8, 8'hE1, 1'b0, 0, 1'b0);
        chk("tok_pv", 64'(snap_pv), 64'd1);
        chk("tok_pid", 64'(snap_pid), 64'h1);
        chk("tok_addr", 64'(snap_addr), 64'h15);
        chk("tok_endp", 64'(snap_endp), 64'hE);
        chk("tok_flags", {61'd0, snap_pe, snap_ce, snap_le}, 64'd0);

        // Same token with an address bit flipped
        bodyq[2] = ~bodyq[2];
        send(8, 8'hE1, 1'b0, 1, 1'b0);
        chk("tokbad_flags", {61'd0, snap_pe, snap_ce, snap_le}, 64'b010);

        // DATA0 00 01 02 03
        bodyq.delete();
        for (int i = 0; i < 4; i++) push_field(64'(i), 8);
        push_crc(16);
        send(8, 8'hC3, 1'b0, 0, 1'b0);
        chk("d0_len", 64'(snap_len), 64'd4);
        chk("d0_data", snap_data, 64'h03020100);
        chk("d0_flags", {61'd0, snap_pe, snap_ce, snap_le}, 64'd0);

        // Zero-length DATA1 with CRC 0x0000
        bodyq.delete();
        chk("model_crc16_empty", 64'(crc_tx(0, 16)), 64'd0);
        push_field(64'd0, 16);
        send(8, 8'h4B, 1'b0, 0, 1'b1);
        chk("d1_len", 64'(snap_len), 64'd0);
        chk("d1_flags", {61'd0, snap_pe, snap_ce, snap_le}, 64'd0);

        // ACK, then a PID with a bad check nibble
        bodyq.delete();
        send(8, 8'hD2, 1'b0, 0, 1'b0);
        chk("ack_pid", 64'(snap_pid), 64'h2);
        chk("ack_flags", {61'd0, snap_pe, snap_ce, snap_le}, 64'd0);
        send(8, 8'hD3, 1'b0, 0, 1'b0);
        chk("badpid_pe", 64'(snap_pe), 64'd1);

        // Token with 15 body bits, data with 88 body bits
        bodyq.delete();
        push_field(64'h15, 7);
        push_field(64'hE, 4);
        push_field(64'hA, 4);
        send(8, 8'hE1, 1'b0, 0, 1'b0);
        chk("tok15_flags", {61'd0, snap_pe, snap_ce, snap_le}, 64'b001);
        bodyq.delete();
        for (int i = 0; i < 11; i++) push_field(64'($urandom_range(0, 255)), 8);
        send(8, 8'hC3, 1'b0, 0, 1'b0);
        chk("d88_flags", {61'd0, snap_pe, snap_ce, snap_le}, 64'b001);

        // Reset after 10 bits of a token discards it
        pb = 8'hE1;
        for (int i = 0; i < 8; i++) drive(1'b1, pb[i], 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        do_reset(1);
        @(negedge clk);
        chk("rstmid_pv", 64'(pktValid), 64'd0);
        chk("rstmid_lenErr", 64'(lenErr), 64'd0);

        // Clean IN token afterwards
        bodyq.delete();
        push_field(64'h3A, 7);
        push_field(64'h5, 4);
        push_crc(5);
        send(8, 8'h69, 1'b0, 0, 1'b0);
        chk("in_pid", 64'(snap_pid), 64'h9);
        chk("in_addr", 64'(snap_addr), 64'h3A);
        chk("in_endp", 64'(snap_endp), 64'h5);
        chk("in_flags", {61'd0, snap_pe, snap_ce, snap_le}, 64'd0);

        // eop alone in IDLE
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_eop_pv", 64'(pktValid), 64'd0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // Final CRC bit arrives together with eop
        bodyq.delete();
        push_field(64'h01, 7);
        push_field(64'h2, 4);
        push_crc(5);
        send(8, 8'h2D, 1'b1, 0, 1'b0);
        chk("merge_pv", 64'(snap_pv), 64'd1);
        chk("merge_addr", 64'(snap_addr), 64'h01);
        chk("merge_flags", {61'd0, snap_pe, snap_ce, snap_le}, 64'd0);

        // Randomized packets
        for (int p = 0; p < 250; p++) begin
            bodyq.delete();
            npid = 8;
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: begin
                    pb = toks[$urandom_range(0, 3)];
                    push_field(64'($urandom_range(0, 127)), 7);
                    push_field(64'($urandom_range(0, 15)), 4);
                    push_crc(5);
                end
                3, 4, 5: begin
                    pb = ($urandom_range(0, 1) == 1) ? 8'hC3 : 8'h4B;
                    len = $urandom_range(0, 8);
                    for (int i = 0; i < len; i++) push_field(64'($urandom_range(0, 255)), 8);
                    push_crc(16);
                end
                6: begin
                    pb = hsks[$urandom_range(0, 2)];
                    if ($urandom_range(0, 3) == 0) push_field(64'($urandom), $urandom_range(1, 8));
                end
                7: begin
                    pb = 8'($urandom);
                    n = $urandom_range(0, 40);
                    for (int i = 0; i < n; i++) bodyq.push_back(1'($urandom));
                end
                8: begin
                    pb = 8'($urandom);
                    npid = $urandom_range(1, 7);
                end
                default: begin
                    pb = 8'hC3;
                    n = $urandom_range(81, 100);
                    for (int i = 0; i < n; i++) bodyq.push_back(1'($urandom));
                end
            endcase
            if (kind <= 5 && bodyq.size() > 0 && $urandom_range(0, 4) == 0) begin
                pos = $urandom_range(0, bodyq.size() - 1);
                bodyq[pos] = ~bodyq[pos];
            end
            if (kind <= 5 && bodyq.size() > 0 && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) void'(bodyq.pop_back());
                else bodyq.push_back(1'($urandom));
            end
            send(npid, pb, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 $urandom_range(0, 3) == 0);
        end

        repeat (5) drive(1'b0, 1'b0, 1'b0);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
